// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// the canonical quiet-NaN pattern for any exponent/fraction split.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Wide enough for any realistic format; callers slice off PRECISION bits.
  localparam int QNAN_MAX_W = 128;

  // {0, all-ones exponent, MSB of fraction set, rest zero}
  function automatic logic [QNAN_MAX_W-1:0] fp_qnan(input int exp_w, input int frac_w);
    logic [QNAN_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[frac_w+i] = 1'b1;
    r[frac_w-1] = 1'b1;
    return r;
  endfunction

  // Subnormals (exp == 0, frac != 0) are deliberately folded into FP_ZERO.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero)      return FP_ZERO;
    else if (exp_ones) return frac_zero ? FP_INF : FP_NAN;
    else               return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe. The producer/consumer side
// uses the master modport, the multiplier uses the slave modport.
interface fp_mul_pipe_if
  import fp_pkg::*;
#(
  parameter int EXPONENT = 8,
  parameter int FRACTION = 23
);
  localparam int PRECISION = 1 + EXPONENT + FRACTION;

  logic                 in_valid;
  logic                 in_ready;
  logic [PRECISION-1:0] a_operand;
  logic [PRECISION-1:0] b_operand;
  logic                 out_valid;
  logic                 out_ready;
  logic [PRECISION-1:0] result;
  logic [FLAG_W-1:0]    flags;

  modport master (
    output in_valid, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a_operand, b_operand, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_round_pack.sv
// Final stage of an IEEE-style datapath: round-to-nearest-even, range check
// and packing of the result word plus exception flags. Purely combinational.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter  int EXPONENT  = 8,
  parameter  int FRACTION  = 23,
  localparam int PRECISION = 1 + EXPONENT + FRACTION,
  localparam int EW        = EXPONENT + 2
) (
  input  logic                 i_sign,
  input  logic signed [EW-1:0] i_exp,
  input  logic [FRACTION-1:0]  i_frac,
  input  logic                 i_guard,
  input  logic                 i_sticky,
  input  fp_class_e            i_class,
  input  logic                 i_invalid,
  output logic [PRECISION-1:0] o_result,
  output logic [FLAG_W-1:0]    o_flags
);

  localparam logic [QNAN_MAX_W-1:0] QNAN_WIDE = fp_qnan(EXPONENT, FRACTION);
  localparam logic [PRECISION-1:0]  QNAN      = QNAN_WIDE[PRECISION-1:0];
  localparam logic signed [EW-1:0]  EXP_INF   = EW'(2**EXPONENT - 1);
  localparam logic signed [EW-1:0]  EXP_ZERO  = '0;

  // Returns {carry, fraction}; a carry means the mantissa wrapped to 1.000..
  function automatic logic [FRACTION:0] rne_round(input logic [FRACTION-1:0] frac,
                                                  input logic g, input logic s);
    logic inc;
    inc = g & (s | frac[0]);
    return {1'b0, frac} + {{FRACTION{1'b0}}, inc};
  endfunction

  function automatic logic sat_overflow(input logic signed [EW-1:0] e);
    return e >= EXP_INF;
  endfunction

  function automatic logic sat_underflow(input logic signed [EW-1:0] e);
    return e <= EXP_ZERO;
  endfunction

  logic [FRACTION:0]   w_rounded;
  logic signed [EW-1:0] w_exp_fin;

  assign w_rounded = rne_round(i_frac, i_guard, i_sticky);
  assign w_exp_fin = i_exp + $signed({{(EW-1){1'b0}}, w_rounded[FRACTION]});

  // Special classes win over range checks; only normal products are rounded.
  always_comb begin
    o_result = '0;
    o_flags  = '0;
    case (i_class)
      FP_NAN: begin
        o_result               = QNAN;
        o_flags[FLAG_INVALID]  = i_invalid;
      end
      FP_INF:  o_result = {i_sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
      FP_ZERO: o_result = {i_sign, {(PRECISION-1){1'b0}}};
      default: begin
        if (sat_overflow(w_exp_fin)) begin
          o_result                = {i_sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
          o_flags[FLAG_OVERFLOW]  = 1'b1;
          o_flags[FLAG_INEXACT]   = 1'b1;
        end else if (sat_underflow(w_exp_fin)) begin
          o_result                = {i_sign, {(PRECISION-1){1'b0}}};
          o_flags[FLAG_UNDERFLOW] = 1'b1;
          o_flags[FLAG_INEXACT]   = 1'b1;
        end else begin
          o_result              = {i_sign, w_exp_fin[EXPONENT-1:0], w_rounded[FRACTION-1:0]};
          o_flags[FLAG_INEXACT] = i_guard | i_sticky;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Four-stage pipelined floating-point multiplier with a single global stall:
// unpack/classify -> mantissa multiply -> 1-bit normalise -> round/pack.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter  int EXPONENT  = 8,
  parameter  int FRACTION  = 23,
  localparam int PRECISION = 1 + EXPONENT + FRACTION,
  localparam int BIAS      = 2**(EXPONENT-1) - 1
) (
  input logic         clk,
  input logic         reset,
  fp_mul_pipe_if.slave bus
);

  localparam int EW = EXPONENT + 2;
  localparam int MW = FRACTION + 1;
  localparam int PW = 2 * FRACTION + 2;

  logic w_advance, w_accept;

  // Stage 1 combinational: unpack and classify
  logic [EXPONENT-1:0]  w_ea, w_eb;
  logic [FRACTION-1:0]  w_fa, w_fb;
  fp_class_e            w_ca, w_cb, w_class_s1;
  logic                 w_inv_s1;
  logic signed [EW-1:0] w_exp_s1;

  // Pipeline registers
  logic                 r_vld_p1, r_vld_p2, r_vld_p3, r_out_vld;
  logic                 r_sign_p1, r_sign_p2, r_sign_p3;
  fp_class_e            r_class_p1, r_class_p2, r_class_p3;
  logic                 r_inv_p1, r_inv_p2, r_inv_p3;
  logic signed [EW-1:0] r_exp_p1, r_exp_p2, r_exp_p3;
  logic [FRACTION-1:0]  r_fa_p1, r_fb_p1, r_frac_p3;
  logic [PW-1:0]        r_prod_p2;
  logic                 r_guard_p3, r_sticky_p3;
  logic [PRECISION-1:0] r_result;
  logic [FLAG_W-1:0]    r_flags;

  // Stage 3 combinational: normalise
  logic [FRACTION-1:0]  w_frac_n;
  logic                 w_guard_n, w_sticky_n;
  logic signed [EW-1:0] w_exp_n;

  logic [PRECISION-1:0] w_pk_result;
  logic [FLAG_W-1:0]    w_pk_flags;

  assign w_advance    = !r_out_vld | bus.out_ready;
  assign w_accept     = bus.in_valid & w_advance;
  assign bus.in_ready = w_advance;

  assign w_ea = bus.a_operand[PRECISION-2 -: EXPONENT];
  assign w_eb = bus.b_operand[PRECISION-2 -: EXPONENT];
  assign w_fa = bus.a_operand[FRACTION-1:0];
  assign w_fb = bus.b_operand[FRACTION-1:0];
  assign w_ca = fp_classify(w_ea == '0, &w_ea, w_fa == '0);
  assign w_cb = fp_classify(w_eb == '0, &w_eb, w_fb == '0);
  assign w_exp_s1 = $signed(EW'(w_ea)) + $signed(EW'(w_eb)) - $signed(EW'(BIAS));

  // Merge both operand classes into the class of the product.
  always_comb begin
    w_class_s1 = FP_NORM;
    w_inv_s1   = 1'b0;
    if (w_ca == FP_NAN || w_cb == FP_NAN) begin
      w_class_s1 = FP_NAN;
    end else if ((w_ca == FP_INF && w_cb == FP_ZERO) || (w_ca == FP_ZERO && w_cb == FP_INF)) begin
      w_class_s1 = FP_NAN;
      w_inv_s1   = 1'b1;
    end else if (w_ca == FP_INF || w_cb == FP_INF) begin
      w_class_s1 = FP_INF;
    end else if (w_ca == FP_ZERO || w_cb == FP_ZERO) begin
      w_class_s1 = FP_ZERO;
    end
  end

  // Product is in [1,4): a set MSB means shift right by one and bump the exponent.
  always_comb begin
    if (r_prod_p2[PW-1]) begin
      w_frac_n   = r_prod_p2[PW-2 -: FRACTION];
      w_guard_n  = r_prod_p2[FRACTION];
      w_sticky_n = |r_prod_p2[FRACTION-1:0];
      w_exp_n    = r_exp_p2 + EW'(1);
    end else begin
      w_frac_n   = r_prod_p2[PW-3 -: FRACTION];
      w_guard_n  = r_prod_p2[FRACTION-1];
      w_sticky_n = |r_prod_p2[FRACTION-2:0];
      w_exp_n    = r_exp_p2;
    end
  end

  // Valid bits march with the data; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (w_advance) begin
      r_vld_p1  <= w_accept;
      r_vld_p2  <= r_vld_p1;
      r_vld_p3  <= r_vld_p2;
      r_out_vld <= r_vld_p3;
    end
  end

  // Datapath stage registers; no reset needed since valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      // S1 -> p1: unpacked operands
      r_sign_p1   <= bus.a_operand[PRECISION-1] ^ bus.b_operand[PRECISION-1];
      r_class_p1  <= w_class_s1;
      r_inv_p1    <= w_inv_s1;
      r_exp_p1    <= w_exp_s1;
      r_fa_p1     <= w_fa;
      r_fb_p1     <= w_fb;
      // S2 -> p2: full mantissa product
      r_sign_p2   <= r_sign_p1;
      r_class_p2  <= r_class_p1;
      r_inv_p2    <= r_inv_p1;
      r_exp_p2    <= r_exp_p1;
      r_prod_p2   <= PW'({1'b1, r_fa_p1}) * PW'({1'b1, r_fb_p1});
      // S3 -> p3: normalised fraction with guard/sticky
      r_sign_p3   <= r_sign_p2;
      r_class_p3  <= r_class_p2;
      r_inv_p3    <= r_inv_p2;
      r_exp_p3    <= w_exp_n;
      r_frac_p3   <= w_frac_n;
      r_guard_p3  <= w_guard_n;
      r_sticky_p3 <= w_sticky_n;
    end
  end

  fp_round_pack #(
    .EXPONENT (EXPONENT),
    .FRACTION (FRACTION)
  ) u_round_pack (
    .i_sign    (r_sign_p3),
    .i_exp     (r_exp_p3),
    .i_frac    (r_frac_p3),
    .i_guard   (r_guard_p3),
    .i_sticky  (r_sticky_p3),
    .i_class   (r_class_p3),
    .i_invalid (r_inv_p3),
    .o_result  (w_pk_result),
    .o_flags   (w_pk_flags)
  );

  // S4 -> output: packed word is captured and held steady while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_advance && r_vld_p3) begin
      r_result <= w_pk_result;
      r_flags  <= w_pk_flags;
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

  logic [MW-1:0] w_unused_mw;
  assign w_unused_mw = '0;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (single precision): directed vectors with literal
// expectations, a scoreboard fed by a value-level model, backpressure and
// mid-stream reset scenarios.
module tb_fp_mul_pipe;
  localparam int EXPONENT = 8;
  localparam int FRACTION = 23;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXPONENT(EXPONENT), .FRACTION(FRACTION)) bus ();

  fp_mul_pipe #(.EXPONENT(EXPONENT), .FRACTION(FRACTION)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [35:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Value-level reference: returns {flags, result}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, top, sh;
    longint unsigned ma, mb, p, q, rem, half;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inexact;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return {4'b0000, 32'h7FC00000};
    if ((a_inf && b_zero) || (a_zero && b_inf)) return {4'b1000, 32'h7FC00000};
    if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {4'b0000, s, 31'h0};
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    p  = ma * mb;
    top = (p >= (64'd1 << 47)) ? 47 : 46;
    e   = ea + eb - 127 + (top - 46);
    sh  = top - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, s, 31'h0};
    return {3'b000, inexact, s, 8'(e), q[22:0]};
  endfunction

  // Scoreboard compare: every cycle, away from the rising edge.
  logic        prev_stall = 1'b0;
  logic [35:0] prev_out   = '0;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'({bus.flags, bus.result}), 64'(prev_out));
      end
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          check("out_valid_without_input", 64'(bus.out_valid), 64'd0);
        end else begin
          check("sb_result", 64'(bus.result), 64'(sb_q[0][31:0]));
          check("sb_flags", 64'(bus.flags), 64'(sb_q[0][35:32]));
          if (bus.out_ready) begin
            void'(sb_q.pop_front());
            n_out++;
          end
        end
      end
      prev_stall = bus.out_valid & !bus.out_ready;
      prev_out   = {bus.flags, bus.result};
      if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.a_operand, bus.b_operand));
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f);
    int lat;
    logic got;
    logic [35:0] m;
    m = model(a, b);
    check({name, "_model"}, 64'(m), 64'({f, r}));
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a_operand = a;
    bus.b_operand = b;
    bus.out_ready = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      #2;
      if (lat == 1) bus.in_valid = 1'b0;
      if (bus.out_valid) got = 1'b1;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
    check({name, "_result"}, 64'(bus.result), 64'(r));
    check({name, "_flags"}, 64'(bus.flags), 64'(f));
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] st_a [8] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'hBF800000,
                            32'h3DCCCCCD, 32'h7F800000, 32'h40490FDB, 32'h00000000};
  logic [31:0] st_b [8] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40000000,
                            32'h41200000, 32'h3F800000, 32'h40490FDB, 32'h80000000};

  task automatic stream(input string name, input int stall_start, input int stall_len);
    int idx, cyc, start_out;
    logic saw_low;
    idx = 0;
    cyc = 0;
    saw_low = 1'b0;
    start_out = n_out;
    while ((idx < 8 || sb_q.size() != 0) && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      if (idx < 8) begin
        bus.in_valid  = 1'b1;
        bus.a_operand = st_a[idx];
        bus.b_operand = st_b[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #2;
      if (bus.in_valid && !bus.in_ready) saw_low = 1'b1;
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({name, "_done_in_budget"}, 64'(cyc < 200), 64'd1);
    check({name, "_count"}, 64'(n_out - start_out), 64'd8);
    if (stall_len > 0) check({name, "_in_ready_dropped"}, 64'(saw_low), 64'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_operand = '0;
    bus.b_operand = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_flags", 64'(bus.flags), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op("basic",    32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_op("neg",      32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    run_op("rne_tie",  32'h3F800001, 32'h40400000, 32'h40400002, 4'b0001);
    run_op("rne_up",   32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    run_op("inf_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_op("ninf",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run_op("nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
    run_op("subnorm",  32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
    run_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    run_op("underflow",32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);

    stream("stream", 0, 0);
    stream("backpressure", 3, 6);

    // Fill the pipe with the output stalled, then reset with 3 ops still in flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'b1;
      bus.a_operand = st_a[i+1];
      bus.b_operand = st_b[i+1];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2;
    check("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_result", 64'(bus.result), 64'd0);
    check("midreset_flags", 64'(bus.flags), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      check("post_reset_quiet", 64'(bus.out_valid), 64'd0);
    end
    run_op("after_reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised, fully IEEE-754-style pipelined floating-point multiplier. It is the successor to the fixed-latency single-precision multiplier used in the chaotic-map datapath.
- Adds valid/ready flow control with backpressure.
- Rounds to nearest even instead of truncating.
- Handles zero, infinity and NaN, and flushes subnormals.
- Reports exception flags per result.
- Sits between the chaotic-map iterators and the key-stream quantiser; one result per cycle when not stalled.

Parameters:
EXPONENT, 8, exponent field width (>=3)
FRACTION, 23, stored fraction width (>=2)
PRECISION, 1+EXPONENT+FRACTION, total word width (derived; do not override)
BIAS, 2**(EXPONENT-1)-1, exponent bias (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
a_operand  in  PRECISION  IEEE-754 operand A
b_operand  in  PRECISION  IEEE-754 operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  PRECISION  IEEE-754 product
flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset:
  - out_valid=0, result=0 and flags=0.
  - All stage valid bits clear; in-flight data is discarded.
  - Reset asserted mid-operation drops every in-flight operand; nothing is emitted after release until new input arrives.
- Pipeline has 4 register stages; latency is 4 cycles from an accepted input to out_valid when unstalled:
  - S1 unpack/classify: sign = sa^sb. Class per operand is zero (exp=0, any fraction; subnormals flushed to zero), inf (exp all-ones, frac=0) or NaN (exp all-ones, frac!=0). Biased exp sum = ea+eb-BIAS in signed EXPONENT+2 bits.
  - S2 multiply: {1,fa}*{1,fb} gives a 2*FRACTION+2 bit product; special-case class is carried alongside.
  - S3 normalise: if product MSB=1, shift right 1 and exp+1. Only a 1-bit normalise is needed; there is no loop. Extract FRACTION bits plus guard bit G and sticky bit S (OR of the remaining bits).
  - S4 round/pack:
    - RNE: increment when G & (S | lsb).
    - A mantissa carry-out increments exp and sets the fraction to 0.
    - inexact = G|S.
- Exception priority, highest first:
  - any NaN, or inf*zero: canonical qNaN {0, all-ones, 1, 0...}. invalid=1 only for inf*zero; NaN inputs propagate quietly.
  - inf*(nonzero): signed inf, no flags.
  - zero*(finite): signed zero, no flags.
  - final biased exp >= 2**EXPONENT-1: signed inf; overflow=1, inexact=1.
  - final biased exp <= 0: signed zero (flush); underflow=1, inexact=1.
- Flow control is a single global stall:
  - advance = !out_valid | out_ready; every stage register loads only when advance=1.
  - in_ready = advance (combinational).
  - An input is accepted when in_valid & in_ready.
  - Bubbles propagate as valid=0 and are not squeezed while stalled.
- Output stability: while out_valid=1 and out_ready=0, result and flags hold constant.
- Simultaneous accept at input and pop at output in the same cycle is legal; sustained throughput is 1 per cycle.
- Results leave in exactly the order operands were accepted; there is no loss and no duplication.
- Exponent arithmetic is signed, EXPONENT+2 bits wide, and never wraps: the largest sum (2*(2^E-2)-BIAS+2) fits.

Decomposition:
- Shared package fp_pkg holds:
  - class encoding typedef (FP_ZERO, FP_NORM, FP_INF, FP_NAN);
  - flag bit index constants;
  - canonical-qNaN constant function of EXPONENT/FRACTION.
- One sub-module, fp_round_pack: takes sign, signed exponent, fraction, G, S and class, and produces result and flags (S4 logic). It is reused by a future fp_add_pipe.

Test Plan:
- Basic product: 0x3FC00000 * 0x40000000 -> 0x40400000, flags=0, out_valid exactly 4 cycles after accept.
- RNE tie and inexact: 0x3F800001 * 0x40400000 -> 0x40400002 with inexact=1; 0x3F800001 * 0x3F800001 -> 0x3F800002 with inexact=1.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000 * 0x40000000 -> 0xFF800000.
  - 0x7FC00001 * 0x3F800000 -> 0x7FC00000, no flags.
  - 0x00000001 (subnormal) * 0x3F800000 -> 0x00000000.
- Range: 0x7F000000 * 0x7F000000 -> 0x7F800000 with overflow=1, inexact=1; 0x00800000 * 0x00800000 -> 0x00000000 with underflow=1, inexact=1.
- Backpressure: stream 8 back-to-back pairs and hold out_ready=0 from cycle 3 for 6 cycles.
  - in_ready must drop.
  - result must stay stable while stalled.
  - All 8 results must emerge in order with no loss or duplication.
- Reset mid-stream: assert reset with 3 operations in flight -> out_valid=0, result=0 and flags=0 immediately. After release nothing is emitted until a new accept, which then returns its result 4 cycles later.
